// File: rtl/load_register_pkg.sv
// -----------------------------------------------------------------------------
// load_register_pkg
// Purpose : Shared constants for the load_register block and its bit cell.
// Contents: DEFAULT_WIDTH     - default number of stored bits (1)
//           DEFAULT_RESET_BIT - default per-bit reset value (0); the top
//                               replicates it to form the WIDTH-bit default
//                               RESET_VALUE.
// -----------------------------------------------------------------------------
package load_register_pkg;

    localparam int   DEFAULT_WIDTH     = 1;
    localparam logic DEFAULT_RESET_BIT = 1'b0;

endpackage : load_register_pkg

// File: rtl/load_register_if.sv
// -----------------------------------------------------------------------------
// load_register_if
// Purpose : Bundles the data/enable inputs and the stored-value output(s) of
//           load_register.
// Signals : in     [WIDTH-1:0] data to be stored
//           load                load enable
//           out    [WIDTH-1:0] currently stored value
//           loaded              sticky "has been loaded since reset" flag,
//                               present only with LOAD_REGISTER_LOADED_FLAG_EN
// Modports: master - drives in/load, observes out (and loaded)
//           slave  - the register itself
// Optional: LOAD_REGISTER_LOADED_FLAG_EN adds the loaded signal.
// -----------------------------------------------------------------------------
interface load_register_if
    import load_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in;
    logic             load;
    logic [WIDTH-1:0] out;
`ifdef LOAD_REGISTER_LOADED_FLAG_EN
    logic             loaded;
`endif

`ifdef LOAD_REGISTER_LOADED_FLAG_EN
    modport master (output in, output load, input out, input loaded);
    modport slave  (input in, input load, output out, output loaded);
`else
    modport master (output in, output load, input out);
    modport slave  (input in, input load, output out);
`endif

endinterface : load_register_if

// File: rtl/load_register_dff_en_cell.sv
// -----------------------------------------------------------------------------
// dff_en_cell
// Purpose : Single-bit rising-edge D flip-flop with synchronous active-high
//           reset, load enable and hold. Reset takes priority over enable.
// Ports   : clk_i  clock
//           rst_i  synchronous reset, active-high (loads RESET_BIT)
//           en_i   load enable
//           d_i    data bit
//           q_o    stored bit (purely registered)
// -----------------------------------------------------------------------------
module dff_en_cell
    import load_register_pkg::*;
#(
    parameter logic RESET_BIT = DEFAULT_RESET_BIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : dff_en_cell

// File: rtl/load_register.sv
// -----------------------------------------------------------------------------
// load_register
// Purpose : WIDTH-bit edge-triggered storage register with load enable, built
//           from WIDTH dff_en_cell instances. On each rising clk edge:
//           reset -> RESET_VALUE, else load -> in, else hold. The output is
//           purely registered; all bits update together.
// Ports   : clk    clock (rising edge only)
//           reset  synchronous reset, active-high, priority over load
//           bus    load_register_if.slave: in, load -> out (and loaded)
// Optional: LOAD_REGISTER_LOADED_FLAG_EN adds a sticky registered `loaded`
//           flag, cleared by reset and set by the first load edge after it.
// -----------------------------------------------------------------------------
module load_register
    import load_register_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
    input  logic              clk,
    input  logic              reset,
    load_register_if.slave    bus
);

    logic [WIDTH-1:0] out_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk_i (clk),
            .rst_i (reset),
            .en_i  (bus.load),
            .d_i   (bus.in[i]),
            .q_o   (out_q[i])
        );
    end

    assign bus.out = out_q;

`ifdef LOAD_REGISTER_LOADED_FLAG_EN
    logic loaded_q;
    logic loaded_d;

    // Sticky: once set it only drops on reset.
    always_comb begin
        loaded_d = loaded_q | bus.load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_q <= 1'b0;
        end else begin
            loaded_q <= loaded_d;
        end
    end

    assign bus.loaded = loaded_q;
`endif

endmodule : load_register

// File: tb/tb_load_register.sv
// -----------------------------------------------------------------------------
// tb_load_register
// Two load_register instances (WIDTH=1 default reset value, and WIDTH=8 with
// RESET_VALUE=8'hA5) share reset/load; a behavioural model tracks the stored
// values and a compare process checks every falling edge once reset has been
// seen. Directed steps add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_load_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld;
    logic [7:0] din;

    load_register_if #(.WIDTH(1)) if_a ();
    load_register_if #(.WIDTH(8)) if_b ();

    load_register #(.WIDTH(1)) u_a (
        .clk   (clk),
        .reset (rst),
        .bus   (if_a.slave)
    );

    load_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_b (
        .clk   (clk),
        .reset (rst),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    assign if_a.in   = din[0];
    assign if_a.load = ld;
    assign if_b.in   = din;
    assign if_b.load = ld;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stored value as seen after the most recent edge.
    logic [7:0] m_a, m_b;
    logic       m_loaded;
    bit         m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_a      = 8'h00;
            m_b      = 8'hA5;
            m_loaded = 1'b0;
            m_valid  = 1;
        end else if (ld) begin
            m_a      = {7'b0, din[0]};
            m_b      = din;
            m_loaded = 1'b1;
        end
    end

    // Compare on falling edges: inputs may have moved, the outputs must not.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out_w1", {7'b0, if_a.out}, m_a);
            check("model_out_w8", if_b.out, m_b);
`ifdef LOAD_REGISTER_LOADED_FLAG_EN
            check("model_loaded", {7'b0, if_a.loaded}, {7'b0, m_loaded});
            check("model_loaded_w8", {7'b0, if_b.loaded}, {7'b0, m_loaded});
`endif
        end
    end

    // Apply inputs, then let one rising edge take them; return 1 unit later.
    task automatic cyc(input logic r, input logic l, input logic [7:0] d);
        rst = r;
        ld  = l;
        din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ld  = 1'b0;
        din = 8'h00;
        @(posedge clk);
        #1;

        // Reset, then a single load.
        cyc(1, 0, 8'h00);
        check("reset_w1", {7'b0, if_a.out}, 8'h00);
        check("reset_w8", if_b.out, 8'hA5);
`ifdef LOAD_REGISTER_LOADED_FLAG_EN
        check("loaded_after_reset", {7'b0, if_a.loaded}, 8'h00);
        cyc(0, 0, 8'hFF);
        check("loaded_no_load", {7'b0, if_a.loaded}, 8'h00);
`endif
        cyc(0, 1, 8'h3D);
        check("load1_w1", {7'b0, if_a.out}, 8'h01);
        check("load_w8", if_b.out, 8'h3D);
`ifdef LOAD_REGISTER_LOADED_FLAG_EN
        check("loaded_first_load", {7'b0, if_a.loaded}, 8'h01);
`endif

        // Hold: load low for several edges while in moves.
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 8'hFF - 8'(i));
        end
        check("hold_w1", {7'b0, if_a.out}, 8'h00);
        check("hold_w8", if_b.out, 8'hA5);
`ifdef LOAD_REGISTER_LOADED_FLAG_EN
        check("loaded_hold_zero", {7'b0, if_a.loaded}, 8'h00);
`endif

        // Falling edge alone must not capture.
        cyc(0, 1, 8'h01);
        rst = 0; ld = 1; din = 8'h00;
        @(negedge clk);
        #1;
        check("negedge_no_effect", {7'b0, if_a.out}, 8'h01);
        @(posedge clk);
        #1;
        check("posedge_capture", {7'b0, if_a.out}, 8'h00);

        // Reset wins over load on the same edge, load resumes next edge.
        cyc(1, 1, 8'h3C);
        check("rst_prio_w1", {7'b0, if_a.out}, 8'h00);
        check("rst_prio_w8", if_b.out, 8'hA5);
`ifdef LOAD_REGISTER_LOADED_FLAG_EN
        check("rst_prio_loaded", {7'b0, if_a.loaded}, 8'h00);
`endif
        cyc(0, 1, 8'h3C);
        check("resume_w1", {7'b0, if_a.out}, 8'h00);
        check("resume_w8", if_b.out, 8'h3C);
        cyc(0, 1, 8'h81);
        check("resume2_w1", {7'b0, if_a.out}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'(i * 37 + 5));
        end
        check("toggle_hold_w8", if_b.out, 8'h81);
`ifdef LOAD_REGISTER_LOADED_FLAG_EN
        check("loaded_sticky", {7'b0, if_a.loaded}, 8'h01);
        cyc(1, 0, 8'h00);
        check("loaded_cleared", {7'b0, if_a.loaded}, 8'h00);
`endif

        // Random traffic, including reset pulses while load toggles.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom));
        end

        // Mid-stream reset with load toggling, then resume.
        cyc(0, 1, 8'h5A);
        cyc(1, 0, 8'h11);
        cyc(1, 1, 8'h22);
        check("midreset_w8", if_b.out, 8'hA5);
        cyc(0, 1, 8'hC3);
        check("midresume_w8", if_b.out, 8'hC3);
        check("midresume_w1", {7'b0, if_a.out}, 8'h01);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_load_register
